demux1_8_32bit: RTL and testbench
=================================

DEMUX1_8_32BIT -- requirements
Module: demux1_8_32bit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the lane count is fixed at 8.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sel  input  3  destination lane index for the current input word.
REQ-005 src_in  input  32  input data word.
REQ-006 in_valid  input  1  producer asserts that src_in/sel are valid this cycle.
REQ-007 in_ready  output  1  the block can accept the word this cycle (combinational).
REQ-008 dst_out0 .. dst_out7  output  32 each  per-lane holding registers.
REQ-009 out_valid  output  8  bit i set means dst_out<i> holds an unconsumed word.
REQ-010 out_ack  input  8  bit i set means the consumer takes dst_out<i> this cycle.
REQ-011 occ_cnt  output  4  number of set out_valid bits (0..8), registered.

Function
REQ-012 The block SHALL compute in_ready = !rst && (!out_valid[sel] || out_ack[sel]).
REQ-013 An input word SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-014 On acceptance, dst_out<sel> SHALL load src_in and out_valid[sel] SHALL be set; the data SHALL be visible on the first cycle after the accepting edge (latency 1).
REQ-015 On a cycle with in_valid && !in_ready, the block SHALL leave all state unchanged; the producer holds src_in/sel stable until it is accepted.
REQ-016 A lane i SHALL be consumed on a rising edge where out_ack[i] && out_valid[i]; out_valid[i] SHALL clear unless the same edge accepts a write to lane i.
REQ-017 A simultaneous consume and write on the same lane SHALL leave out_valid[i]=1 with dst_out<i> holding the new word (pass-through; no bubble).
REQ-018 out_ack[i] asserted while out_valid[i]=0 SHALL be ignored.
REQ-019 Any subset of out_ack bits MAY be asserted together; each lane SHALL be consumed independently in the same cycle.
REQ-020 dst_out<i> SHALL retain its last value after consumption; only an accepted write SHALL change it.
REQ-021 Lanes other than sel SHALL NOT be affected by a write, including when they are full.
REQ-022 occ_cnt SHALL equal the popcount of out_valid at every cycle; its next value = occ_cnt + (write to an empty-or-not-consumed lane) - (consumes not replaced by a write), saturating never, range 0..8.
REQ-023 With all 8 lanes full and no out_ack, in_ready SHALL be 0 for every sel and occ_cnt SHALL read 8.

Reset
REQ-024 While rst=1, dst_out0..7 SHALL be 32'h00000000, out_valid SHALL be 8'h00, occ_cnt SHALL be 4'd0, and in_ready SHALL be 0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard all unconsumed words immediately; out_ack/in_valid during reset SHALL have no effect.
REQ-026 On the first rising edge after rst deasserts, the block SHALL accept a valid input (in_ready=1 for any sel).

Verification
REQ-027 Reset then sel=3, src_in=32'hDEADBEEF, in_valid=1 for one cycle -> next cycle dst_out3=DEADBEEF, out_valid=8'h08, occ_cnt=1; all other dst_out=0.
REQ-028 Fill lanes 0..7 with 32'h1000_000i without acks -> out_valid=8'hFF, occ_cnt=8; then sel=5, in_valid=1 -> in_ready=0 and dst_out5 stays 32'h10000005.
REQ-029 Lane 5 full, sel=5, src_in=32'hCAFEF00D, in_valid=1, out_ack=8'h20 in the same cycle -> in_ready=1; next cycle dst_out5=CAFEF00D, out_valid[5]=1, occ_cnt unchanged.
REQ-030 Lanes 0,2,7 full, out_ack=8'h85 (includes idle lane... bit 0,2,7) plus out_ack[1]=1 on an empty lane -> next cycle out_valid=0, occ_cnt=0, dst_out0/2/7 retain their data.
REQ-031 4 lanes full, assert rst asynchronously between edges -> out_valid, occ_cnt, and all dst_out go to 0 before the next edge; in_ready=0 until rst deasserts.

Source files
------------

// File: rtl/demux1_8_32bit.sv
// One-to-eight demultiplexer with a 32-bit holding register per lane.
// Each lane has its own valid/ack handshake; occ_cnt is a registered count of full lanes.
module demux1_8_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic [31:0] src_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] dst_out0,
  output logic [31:0] dst_out1,
  output logic [31:0] dst_out2,
  output logic [31:0] dst_out3,
  output logic [31:0] dst_out4,
  output logic [31:0] dst_out5,
  output logic [31:0] dst_out6,
  output logic [31:0] dst_out7,
  output logic [7:0]  out_valid,
  input  logic [7:0]  out_ack,
  output logic [3:0]  occ_cnt
);

  localparam int LANES = 8;

  logic [31:0] data_q [LANES];
  logic [7:0]  valid_q, valid_d;
  logic [3:0]  occ_q, occ_d;
  logic        accept;

  // A full lane can still take a word when its consumer drains it on the same edge.
  always_comb begin
    in_ready = !rst && (!valid_q[sel] || out_ack[sel]);
    accept   = in_valid && in_ready;
  end

  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional update, so no latch can be inferred.
  always_comb begin
    valid_d = valid_q & ~out_ack;
    if (accept) begin
      valid_d[sel] = 1'b1;
    end
    occ_d = '0;
    for (int i = 0; i < LANES; i++) begin
      occ_d = occ_d + {3'b000, valid_d[i]};
    end
  end

  // NOTE: the holding registers are reset along with the control state because
  // they drive the outputs directly and must read zero while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      if (accept) begin
        data_q[sel] <= src_in;
      end
    end
  end

  assign out_valid = valid_q;
  assign occ_cnt   = occ_q;
  assign dst_out0  = data_q[0];
  assign dst_out1  = data_q[1];
  assign dst_out2  = data_q[2];
  assign dst_out3  = data_q[3];
  assign dst_out4  = data_q[4];
  assign dst_out5  = data_q[5];
  assign dst_out6  = data_q[6];
  assign dst_out7  = data_q[7];

endmodule

// File: tb/tb_demux1_8_32bit.sv
// Self-checking bench for demux1_8_32bit: directed scenarios followed by a
// randomized run, all compared against a lane-by-lane behavioural model.
module tb_demux1_8_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [31:0] src_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dst_out0, dst_out1, dst_out2, dst_out3;
  logic [31:0] dst_out4, dst_out5, dst_out6, dst_out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [3:0]  occ_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data  [8];
  bit          m_full  [8];
  logic [31:0] dut_data [8];

  demux1_8_32bit dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .src_in   (src_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dst_out0 (dst_out0),
    .dst_out1 (dst_out1),
    .dst_out2 (dst_out2),
    .dst_out3 (dst_out3),
    .dst_out4 (dst_out4),
    .dst_out5 (dst_out5),
    .dst_out6 (dst_out6),
    .dst_out7 (dst_out7),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .occ_cnt  (occ_cnt)
  );

  always #5 clk = ~clk;

  assign dut_data[0] = dst_out0;
  assign dut_data[1] = dst_out1;
  assign dut_data[2] = dst_out2;
  assign dut_data[3] = dst_out3;
  assign dut_data[4] = dst_out4;
  assign dut_data[5] = dst_out5;
  assign dut_data[6] = dst_out6;
  assign dut_data[7] = dst_out7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    foreach (m_full[i]) if (m_full[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] model_valid_vec();
    logic [7:0] v = '0;
    foreach (m_full[i]) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic model_ready(input logic [2:0] s, input logic [7:0] a);
    return !m_full[s] || a[s];
  endfunction

  task automatic model_reset();
    foreach (m_full[i]) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, " out_valid"}, {24'h0, out_valid}, {24'h0, model_valid_vec()});
    check({ctx, " occ_cnt"}, {28'h0, occ_cnt}, model_count());
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s dst_out%0d", ctx, i), dut_data[i], m_data[i]);
    end
  endtask

  // Drives one cycle from a negedge, checks in_ready before the edge and the
  // full register state after it; returns whether the word was accepted.
  task automatic step(input string ctx, input logic [2:0] s, input logic [31:0] d,
                      input logic v, input logic [7:0] a, output logic took);
    logic rdy;
    sel = s; src_in = d; in_valid = v; out_ack = a;
    rdy = model_ready(s, a);
    #1 check({ctx, " in_ready"}, {31'h0, in_ready}, {31'h0, rdy});
    @(posedge clk);
    took = v && rdy;
    for (int i = 0; i < 8; i++) if (a[i]) m_full[i] = 1'b0;
    if (took) begin
      m_full[s] = 1'b1;
      m_data[s] = d;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ack  = '0;
    check_all(ctx);
  endtask

  initial begin
    logic        took;
    logic [2:0]  p_sel;
    logic [31:0] p_data;
    logic        pending;

    rst = 1'b1; sel = '0; src_in = '0; in_valid = 1'b0; out_ack = '0;
    model_reset();
    repeat (2) @(negedge clk);
    in_valid = 1'b1; out_ack = 8'hFF; sel = 3'd4;
    #1 check("reset in_ready", {31'h0, in_ready}, 32'h0);
    check_all("reset");
    in_valid = 1'b0; out_ack = '0;
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = s[2:0];
      #1 check($sformatf("post-reset in_ready sel%0d", s), {31'h0, in_ready}, 32'h1);
    end

    step("single write", 3'd3, 32'hDEADBEEF, 1'b1, 8'h00, took);

    rst = 1'b1; #1 model_reset(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step($sformatf("fill%0d", i), i[2:0], 32'h1000_0000 | i, 1'b1, 8'h00, took);
    end
    for (int s = 0; s < 8; s++) begin
      sel = s[2:0];
      #1 check($sformatf("all-full in_ready sel%0d", s), {31'h0, in_ready}, 32'h0);
    end
    step("write to full lane", 3'd5, 32'hBAD0BAD0, 1'b1, 8'h00, took);
    step("pass-through", 3'd5, 32'hCAFEF00D, 1'b1, 8'h20, took);

    rst = 1'b1; #1 model_reset(); rst = 1'b0;
    step("fill0", 3'd0, 32'hA0A0A0A0, 1'b1, 8'h00, took);
    step("fill2", 3'd2, 32'hA2A2A2A2, 1'b1, 8'h00, took);
    step("fill7", 3'd7, 32'hA7A7A7A7, 1'b1, 8'h00, took);
    step("multi ack", 3'd0, 32'h0, 1'b0, 8'h87, took);

    for (int i = 0; i < 4; i++) begin
      step($sformatf("pre-reset fill%0d", i), i[2:0] + 3'd2, $urandom, 1'b1, 8'h00, took);
    end
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async reset");
    in_valid = 1'b1; out_ack = 8'hFF; sel = 3'd2;
    #1 check("in_ready during reset", {31'h0, in_ready}, 32'h0);
    @(posedge clk); @(negedge clk);
    check_all("reset held over edge");
    in_valid = 1'b0; out_ack = '0; rst = 1'b0;

    pending = 1'b0; p_sel = '0; p_data = '0;
    for (int n = 0; n < 400; n++) begin
      logic        v;
      logic [7:0]  a;
      if (!pending) begin
        p_sel  = 3'($urandom_range(0, 7));
        p_data = $urandom;
      end
      v = pending || ($urandom_range(0, 3) != 0);
      a = 8'($urandom & $urandom);
      step($sformatf("rand%0d", n), p_sel, p_data, v, a, took);
      pending = v && !took;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
